// File: rtl/compute_sequencer.sv
// compute_sequencer: job sequencer for a MUL_SIZE x MUL_SIZE systolic array.
// It paces each weight tile through wait -> prime -> compute, overlaps the
// next tile's weight load with the current tile's tail via a diagonal swap,
// and drains the array at the end of the job.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  job start pulse (ignored while busy_o=1)
//   rows_i, tiles_i          rows per tile / tiles per job, sampled with start_i
//   weights_rdy_i            next weight tile is sitting in the shadow buffer
//   weight_sel_o             per-column active weight-buffer select
//   weight_consume_o         one-cycle pulse: a shadow tile was taken
//   act_load_o, mac_en_o     activation feed and MAC enable
//   stall_o                  array is not computing
//   tile_done_o, done_o      one-cycle pulses at tile end / job end
//   busy_o                   state is not IDLE
//   dbg_state_o              current FSM state, for observation only
//
// Weight handshake: weights_rdy_i is a level from the weight loader; the tile
// counts as taken on the clock edge where the sequencer samples
// weights_rdy_i=1 while it wants a tile (end of WAIT_W, or the tile-end edge
// that enters SWAP). weight_consume_o is high for the one cycle after that
// edge, and the loader must then drop weights_rdy_i until the next tile is
// staged.
//
// All outputs are registered. Pulses (weight_consume_o, tile_done_o, done_o)
// are set on the edge that takes the corresponding decision, so they are
// visible during the first cycle of the state that follows it.
module compute_sequencer #(
    parameter int MUL_SIZE = 32,
    parameter int ROW_W    = 10,
    parameter int TILE_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [ROW_W-1:0]    rows_i,
    input  logic [TILE_W-1:0]   tiles_i,
    input  logic                weights_rdy_i,
    output logic [MUL_SIZE-1:0] weight_sel_o,
    output logic                weight_consume_o,
    output logic                act_load_o,
    output logic                mac_en_o,
    output logic                stall_o,
    output logic                tile_done_o,
    output logic                done_o,
    output logic                busy_o,
    output logic [2:0]          dbg_state_o
);

    localparam int PH_W = $clog2(2 * MUL_SIZE);
    localparam logic [ROW_W-1:0]    MS_ROWS   = ROW_W'(MUL_SIZE);
    localparam logic [PH_W-1:0]     SWAP_LAST = PH_W'(MUL_SIZE - 1);
    localparam logic [PH_W-1:0]     DRN_LAST  = PH_W'(2 * MUL_SIZE - 2);
    localparam logic [MUL_SIZE-1:0] COL0      = {{(MUL_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, WAIT_W, PRIME, COMPUTE, SWAP, DRAIN, DONE
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  rows_eff;
    logic [TILE_W-1:0] tiles;
    logic [ROW_W-1:0]  row_cnt;
    logic [TILE_W-1:0] tile_cnt;
    logic [PH_W-1:0]   phase;
    logic              tile_end;

    assign dbg_state_o = state;

    // The last row of a tile normally falls in COMPUTE. When rows_eff equals
    // MUL_SIZE the whole new tile is covered by SWAP, so its last row is the
    // final SWAP cycle and the tile must end there.
    assign tile_end = (row_cnt == rows_eff - ROW_W'(1)) &&
                      ((state == COMPUTE) ||
                       (state == SWAP && phase == SWAP_LAST));

    // Level outputs of a state: {act_load, mac_en, stall, busy}.
    function automatic logic [3:0] levels(input state_t s);
        case (s)
            IDLE:    levels = 4'b0010;
            WAIT_W:  levels = 4'b0011;
            PRIME:   levels = 4'b1011;
            COMPUTE: levels = 4'b1101;
            SWAP:    levels = 4'b1101;
            DRAIN:   levels = 4'b0101;
            default: levels = 4'b0011;  // DONE
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            rows_eff         <= '0;
            tiles            <= '0;
            row_cnt          <= '0;
            tile_cnt         <= '0;
            phase            <= '0;
            weight_sel_o     <= '0;
            weight_consume_o <= 1'b0;
            tile_done_o      <= 1'b0;
            done_o           <= 1'b0;
            {act_load_o, mac_en_o, stall_o, busy_o} <= levels(IDLE);
        end else begin
            weight_consume_o <= 1'b0;
            tile_done_o      <= 1'b0;
            done_o           <= 1'b0;

            if (tile_end) begin
                tile_done_o <= 1'b1;
                row_cnt     <= '0;
                tile_cnt    <= tile_cnt + TILE_W'(1);
                phase       <= '0;
                if (tile_cnt == tiles - TILE_W'(1)) begin
                    state <= DRAIN;
                    {act_load_o, mac_en_o, stall_o, busy_o} <= levels(DRAIN);
                end else if (weights_rdy_i) begin
                    // Start the diagonal wavefront with column 0.
                    weight_consume_o <= 1'b1;
                    weight_sel_o     <= weight_sel_o ^ COL0;
                    state            <= SWAP;
                    {act_load_o, mac_en_o, stall_o, busy_o} <= levels(SWAP);
                end else begin
                    state <= WAIT_W;
                    {act_load_o, mac_en_o, stall_o, busy_o} <= levels(WAIT_W);
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            rows_eff <= (rows_i < MS_ROWS) ? MS_ROWS : rows_i;
                            tiles    <= tiles_i;
                            row_cnt  <= '0;
                            tile_cnt <= '0;
                            phase    <= '0;
                            if (tiles_i == '0) begin
                                done_o <= 1'b1;
                                state  <= DONE;
                                {act_load_o, mac_en_o, stall_o, busy_o} <= levels(DONE);
                            end else begin
                                state <= WAIT_W;
                                {act_load_o, mac_en_o, stall_o, busy_o} <= levels(WAIT_W);
                            end
                        end
                    end
                    WAIT_W: begin
                        if (weights_rdy_i) begin
                            // Array is stalled, so every column flips at once.
                            weight_sel_o     <= ~weight_sel_o;
                            weight_consume_o <= 1'b1;
                            phase            <= '0;
                            state            <= PRIME;
                            {act_load_o, mac_en_o, stall_o, busy_o} <= levels(PRIME);
                        end
                    end
                    PRIME: begin
                        if (phase == PH_W'(1)) begin
                            phase <= '0;
                            state <= COMPUTE;
                            {act_load_o, mac_en_o, stall_o, busy_o} <= levels(COMPUTE);
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    COMPUTE: begin
                        row_cnt <= row_cnt + ROW_W'(1);
                    end
                    SWAP: begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        if (phase == SWAP_LAST) begin
                            phase <= '0;
                            state <= COMPUTE;
                            {act_load_o, mac_en_o, stall_o, busy_o} <= levels(COMPUTE);
                        end else begin
                            // Column k flips on entry to SWAP cycle k.
                            phase        <= phase + PH_W'(1);
                            weight_sel_o <= weight_sel_o ^ (COL0 << (phase + PH_W'(1)));
                        end
                    end
                    DRAIN: begin
                        if (phase == DRN_LAST) begin
                            phase  <= '0;
                            done_o <= 1'b1;
                            state  <= DONE;
                            {act_load_o, mac_en_o, stall_o, busy_o} <= levels(DONE);
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    default: begin  // DONE
                        state <= IDLE;
                        {act_load_o, mac_en_o, stall_o, busy_o} <= levels(IDLE);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_compute_sequencer.sv
// tb_compute_sequencer: randomized job-level bench for compute_sequencer
// (MUL_SIZE=4). The reference model walks each job as a sequence of phases
// (wait, prime, rows, swap, drain, done) and predicts every output cycle.
module tb_compute_sequencer;

    localparam int M  = 4;
    localparam int RW = 10;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [RW-1:0] rows_in;
    logic [TW-1:0] tiles_in;
    logic          rdy;
    logic [M-1:0]  weight_sel;
    logic          consume;
    logic          act_load;
    logic          mac_en;
    logic          stall;
    logic          tile_done;
    logic          done;
    logic          busy;
    logic [2:0]    dbg_state;

    compute_sequencer #(.MUL_SIZE(M), .ROW_W(RW), .TILE_W(TW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .rows_i           (rows_in),
        .tiles_i          (tiles_in),
        .weights_rdy_i    (rdy),
        .weight_sel_o     (weight_sel),
        .weight_consume_o (consume),
        .act_load_o       (act_load),
        .mac_en_o         (mac_en),
        .stall_o          (stall),
        .tile_done_o      (tile_done),
        .done_o           (done),
        .busy_o           (busy),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           total = 0;
    int           bad   = 0;
    logic [M-1:0] m_sel = '0;   // modelled weight-select columns
    int           wplan[16];    // per tile: 0 = swap overlap, n = n WAIT_W cycles

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Packs {weight_sel, consume, act, mac, stall, tile_done, done, busy}.
    task automatic expect_out(input string tag, input bit cons, input bit act, input bit mac,
                              input bit stl, input bit td, input bit dn, input bit bz);
        check(tag, {weight_sel, consume, act_load, mac_en, stall, tile_done, done, busy},
                   {m_sel, cons, act, mac, stl, td, dn, bz});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Random input activity the DUT must ignore while busy.
    task automatic noise;
        start    = 1'($urandom_range(0, 1));
        rows_in  = RW'($urandom_range(0, 1023));
        tiles_in = TW'($urandom_range(0, 15));
        rdy      = 1'($urandom_range(0, 1));
    endtask

    // Runs one whole job from IDLE and checks every cycle until IDLE again.
    task automatic run_job(input int rows, input int tiles);
        int reff;
        bit via_wait;
        int wait_left;
        reff     = (rows < M) ? M : rows;
        start    = 1'b1;
        rows_in  = RW'(rows);
        tiles_in = TW'(tiles);
        rdy      = 1'($urandom_range(0, 1));
        tick;
        start = 1'b0;
        if (tiles == 0) begin
            expect_out("done_zero_tiles", 0, 0, 0, 1, 0, 1, 1);
            noise;
            tick;
            expect_out("idle_after_zero", 0, 0, 0, 1, 0, 0, 0);
            start = 1'b0;
            return;
        end
        expect_out("wait_first", 0, 0, 0, 1, 0, 0, 1);
        via_wait  = 1'b1;
        wait_left = wplan[0];
        for (int t = 0; t < tiles; t++) begin
            if (via_wait) begin
                for (int w = 0; w < wait_left; w++) begin
                    noise;
                    rdy = 1'b0;
                    tick;
                    expect_out("wait", 0, 0, 0, 1, 0, 0, 1);
                end
                noise;
                rdy = 1'b1;
                tick;
                m_sel = ~m_sel;
                expect_out("prime0", 1, 1, 0, 1, 0, 0, 1);
                noise;
                tick;
                expect_out("prime1", 0, 1, 0, 1, 0, 0, 1);
                for (int r = 0; r < reff; r++) begin
                    noise;
                    tick;
                    expect_out("compute", 0, 1, 1, 0, 0, 0, 1);
                end
            end else begin
                // SWAP cycle 0 was checked at the tile boundary.
                for (int k = 1; k < M; k++) begin
                    noise;
                    tick;
                    m_sel[k] = ~m_sel[k];
                    expect_out("swap", 0, 1, 1, 0, 0, 0, 1);
                end
                for (int r = M; r < reff; r++) begin
                    noise;
                    tick;
                    expect_out("compute_after_swap", 0, 1, 1, 0, 0, 0, 1);
                end
            end
            if (t == tiles - 1) begin
                noise;
                tick;
                expect_out("drain0", 0, 0, 1, 0, 1, 0, 1);
                for (int d = 1; d < 2 * M - 1; d++) begin
                    noise;
                    tick;
                    expect_out("drain", 0, 0, 1, 0, 0, 0, 1);
                end
                noise;
                tick;
                expect_out("done", 0, 0, 0, 1, 0, 1, 1);
                noise;
                tick;
                expect_out("idle", 0, 0, 0, 1, 0, 0, 0);
                start = 1'b0;
            end else if (wplan[t + 1] == 0) begin
                noise;
                rdy = 1'b1;
                tick;
                m_sel[0] = ~m_sel[0];
                expect_out("swap0", 1, 1, 1, 0, 1, 0, 1);
                via_wait = 1'b0;
            end else begin
                noise;
                rdy = 1'b0;
                tick;
                expect_out("wait_tile_end", 0, 0, 0, 1, 1, 0, 1);
                via_wait  = 1'b1;
                wait_left = wplan[t + 1] - 1;
            end
        end
    endtask

    task automatic clear_plan;
        for (int i = 0; i < 16; i++) wplan[i] = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rows_in  = '0;
        tiles_in = '0;
        rdy      = 1'b0;
        clear_plan;
        #12;
        expect_out("reset_state", 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single tile, shadow tile already present.
        run_job(6, 1);
        // Two tiles with swap overlap.
        run_job(8, 2);
        // Two tiles, weights late at the tile boundary for 5 cycles.
        wplan[1] = 5;
        run_job(8, 2);
        clear_plan;
        // Rows below the array edge are padded up to MUL_SIZE.
        run_job(2, 1);
        // Padded rows with swap overlap covering the whole tile.
        run_job(2, 3);
        // Zero tiles: immediate done.
        run_job(5, 0);

        // Reset in the middle of SWAP cycle 2.
        start    = 1'b1;
        rows_in  = RW'(8);
        tiles_in = TW'(2);
        rdy      = 1'b1;
        tick;
        start = 1'b0;
        repeat (13) tick;
        m_sel = ~m_sel;
        m_sel = m_sel ^ 4'b0111;
        check("sel_at_swap2", weight_sel, m_sel);
        check("busy_at_swap2", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        m_sel = '0;
        expect_out("async_reset", 0, 0, 0, 1, 0, 0, 0);
        tick;
        expect_out("reset_held", 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(6, 1);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            int rws;
            int tls;
            rws = $urandom_range(0, 12);
            tls = $urandom_range(0, 4);
            for (int i = 0; i < 16; i++) wplan[i] = $urandom_range(0, 3);
            run_job(rws, tls);
            repeat ($urandom_range(0, 3)) begin
                start = 1'b0;
                rdy   = 1'($urandom_range(0, 1));
                tick;
                expect_out("idle_gap", 0, 0, 0, 1, 0, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compute_sequencer.md
COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter MUL_SIZE, default 32, gives the systolic array edge and the number of weight-select columns.
REQ-002 Parameter ROW_W, default 10, gives the width of the row count per tile.
REQ-003 Parameter TILE_W, default 4, gives the width of the weight-tile count per job.
REQ-004 Port clk_i, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 Port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port start_i, input, 1 bit: job start pulse.
REQ-007 Port rows_i, input, ROW_W bits: activation rows per tile, sampled with start_i.
REQ-008 Port tiles_i, input, TILE_W bits: weight tiles per job, sampled with start_i.
REQ-009 Port weights_rdy_i, input, 1 bit: the next weight tile is present in the shadow buffer.
REQ-010 Port weight_sel_o, output, MUL_SIZE bits: per-column active weight-buffer select.
REQ-011 Port weight_consume_o, output, 1 bit: one-cycle pulse when a shadow tile is taken.
REQ-012 Port act_load_o, output, 1 bit: feed activations into the array.
REQ-013 Port mac_en_o, output, 1 bit: MAC enable.
REQ-014 Port stall_o, output, 1 bit: array stalled.
REQ-015 Port tile_done_o, output, 1 bit: one-cycle pulse at the last row of each tile.
REQ-016 Port done_o, output, 1 bit: one-cycle pulse at job end.
REQ-017 Port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 The state machine SHALL have the states IDLE, WAIT_W, PRIME, COMPUTE, SWAP, DRAIN and DONE; all outputs SHALL be registered.
REQ-019 In IDLE, start_i=1 SHALL latch rows_eff=max(rows_i, MUL_SIZE) and tiles_i, clear row_cnt and tile_cnt, and go to WAIT_W; if tiles_i=0, the block SHALL go to DONE instead.
REQ-020 start_i SHALL be ignored whenever busy_o=1.
REQ-021 In WAIT_W, stall_o=1 and mac_en_o=0; on weights_rdy_i=1, all weight_sel_o bits SHALL invert, weight_consume_o SHALL pulse, and the next state SHALL be PRIME.
REQ-022 PRIME SHALL last exactly 2 cycles with act_load_o=1, stall_o=1 and mac_en_o=0, then go to COMPUTE.
REQ-023 COMPUTE drive and counting:
  - act_load_o=1, mac_en_o=1, stall_o=0.
  - row_cnt increments by 1 per cycle.
REQ-024 In COMPUTE, weights_rdy_i is not checked; the current tile is already resident.
REQ-025 When row_cnt=rows_eff-1 in COMPUTE, tile_done_o SHALL pulse, row_cnt SHALL clear, tile_cnt SHALL increment, and the next state SHALL be chosen in this priority:
  - last tile (tile_cnt=tiles-1) -> DRAIN.
  - else weights_rdy_i=1 -> SWAP, with weight_consume_o pulsing the same cycle.
  - else -> WAIT_W.
REQ-026 SWAP SHALL last exactly MUL_SIZE cycles:
  - in SWAP cycle k (k=0..MUL_SIZE-1), only weight_sel_o[k] inverts (diagonal wavefront).
  - mac_en_o=1, act_load_o=1, and row_cnt keeps counting rows of the new tile.
  - after cycle MUL_SIZE-1 the next state is COMPUTE with row_cnt=MUL_SIZE.
REQ-027 DRAIN SHALL last exactly 2*MUL_SIZE-1 cycles with act_load_o=0, mac_en_o=1, stall_o=0, then go to DONE.
REQ-028 DONE SHALL last 1 cycle with done_o=1 and all other pulses 0, then go to IDLE.
REQ-029 weight_sel_o SHALL persist across jobs and SHALL NOT be cleared at job end.
REQ-030 Counter widths: row_cnt ROW_W bits, tile_cnt TILE_W bits, phase counter clog2(2*MUL_SIZE) bits; no counter SHALL wrap within a legal job.

Reset
REQ-031 While rst_ni=0, the block SHALL immediately go to IDLE with weight_sel_o='0, stall_o=1, busy_o=0, and all other outputs and counters 0, including when reset arrives mid-job.
REQ-032 After rst_ni rises, the first start_i SHALL be honoured on the first clock edge.

Verification (MUL_SIZE=4)
REQ-033 rows_i=6, tiles_i=1, weights_rdy_i=1 -> weight_sel_o 0000->1111 and 1 weight_consume_o pulse; PRIME 2 cycles; 6 mac_en_o cycles; tile_done_o once; DRAIN 7 cycles; done_o pulses 16 cycles after start_i.
REQ-034 rows_i=8, tiles_i=2, weights_rdy_i held 1 -> SWAP toggles bits 0,1,2,3 on successive cycles; mac_en_o continuous for 16 cycles; 2 tile_done_o pulses; 2 weight_consume_o pulses.
REQ-035 Same as REQ-034 but weights_rdy_i=0 at the end of tile 0 for 5 cycles -> WAIT_W 5 cycles with stall_o=1; then all bits invert and PRIME runs before tile 1.
REQ-036 rows_i=2 -> rows_eff=4; 4 COMPUTE cycles per tile.
REQ-037 tiles_i=0 -> done_o pulses 1 cycle after start_i, with no mac_en_o and no weight_consume_o.
REQ-038 Drive rst_ni=0 during SWAP cycle 2 -> outputs reach reset values without a clock edge; a new start_i after release runs the REQ-033 sequence exactly.
